// File: rtl/tpu_pkg.sv
// Shared TPU definitions: unified buffer defaults and the response-pipeline tag.
// Provides DEF_* parameter defaults, beat_bytes() and ub_tag_t.
package tpu_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_BANKING_FACTOR = 1;
   localparam int DEF_ADDRESS_WIDTH  = 13;
   localparam int DEF_MEM_LATENCY    = 2;

   function automatic int beat_bytes(input int bf, input int dw);
      return bf * dw / 8;
   endfunction

   localparam int DEF_BYTES_PER_BEAT =
      beat_bytes(DEF_BANKING_FACTOR, DEF_DATA_WIDTH);

   // Travels alongside each read: who asked for it, and whether it is live.
   typedef struct packed {
      logic valid;
      logic host;
   } ub_tag_t;

endpackage

// File: rtl/ub_bank.sv
// Single-port synchronous RAM bank, registered read, write has no read.
// Ports: clk, we, re, addr (row), wdata, rdata (registered).
module ub_bank
   import tpu_pkg::*;
#(
   parameter int DW = DEF_DATA_WIDTH,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/unified_buffer.sv
// Banked unified buffer: priority compute port plus valid/ready host port.
// Ports: clk, rst, mem_req_*/mem_*_en/mem_resp_data, host_*, err_rw_conflict.
module unified_buffer
   import tpu_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int BANKING_FACTOR = DEF_BANKING_FACTOR,
   parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
   parameter int MEM_LATENCY    = DEF_MEM_LATENCY
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ADDRESS_WIDTH-1:0]           mem_req_addr,
   input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
   input  logic                               mem_read_en,
   input  logic                               mem_write_en,
   output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
   input  logic                               host_valid,
   output logic                               host_ready,
   input  logic                               host_we,
   input  logic [ADDRESS_WIDTH-1:0]           host_addr,
   input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_wdata,
   output logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_rdata,
   output logic                               host_rvalid,
   output logic                               err_rw_conflict
);

   localparam int BW    = BANKING_FACTOR * DATA_WIDTH;
   localparam int BPB   = beat_bytes(BANKING_FACTOR, DATA_WIDTH);
   localparam int OFS   = $clog2(BPB);
   localparam int ROW_W = ADDRESS_WIDTH - OFS;
   localparam int NST   = (MEM_LATENCY > 1) ? MEM_LATENCY - 1 : 1;

   logic             c_act, h_acc, we, re;
   logic [ROW_W-1:0] row;
   logic [BW-1:0]    wbeat, rbeat, l_dat;
   logic [BW-1:0]    resp_q, hdat_q;
   ub_tag_t          tq [NST];
   ub_tag_t          l_tag;

   assign c_act      = mem_read_en || mem_write_en;
   assign host_ready = !c_act;
   assign h_acc      = host_valid && host_ready;
   assign we         = mem_write_en || (h_acc && host_we);
   // A simultaneous read+write strobe is treated as a write only.
   assign re         = (mem_read_en && !mem_write_en) || (h_acc && !host_we);
   // Row width truncation gives modulo-DEPTH wrap; low byte bits drop out.
   assign row   = c_act ? ROW_W'(mem_req_addr >> OFS)
                        : ROW_W'(host_addr >> OFS);
   assign wbeat = c_act ? mem_req_data : host_wdata;

   for (genvar b = 0; b < BANKING_FACTOR; b++) begin : g_bank
      ub_bank #(.DW(DATA_WIDTH), .AW(ROW_W)) u_bank (
         .clk   (clk),
         .we    (we),
         .re    (re),
         .addr  (row),
         .wdata (wbeat[b*DATA_WIDTH +: DATA_WIDTH]),
         .rdata (rbeat[b*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_rw_conflict <= 1'b0;
      else if (mem_read_en && mem_write_en) err_rw_conflict <= 1'b1;
   end

   // tq[0] lines up with the bank read register; later entries delay it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NST; i++) tq[i] <= '0;
      end else begin
         tq[0] <= '{valid: re, host: !c_act};
         for (int i = 1; i < NST; i++) tq[i] <= tq[i-1];
      end
   end

   assign l_tag = tq[NST-1];

   if (MEM_LATENCY <= 2) begin : g_nodly
      assign l_dat = rbeat;
   end else begin : g_dly
      logic [BW-1:0] dq [MEM_LATENCY-2];
      always_ff @(posedge clk) begin
         dq[0] <= rbeat;
         for (int i = 1; i < MEM_LATENCY-2; i++) dq[i] <= dq[i-1];
      end
      assign l_dat = dq[MEM_LATENCY-3];
   end

   if (MEM_LATENCY == 1) begin : g_lat1
      // Response is the bank register itself, held once the tag moves on.
      assign mem_resp_data = (l_tag.valid && !l_tag.host) ? l_dat : resp_q;
      assign host_rdata    = (l_tag.valid && l_tag.host) ? l_dat : hdat_q;
      assign host_rvalid   = l_tag.valid && l_tag.host;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            resp_q <= '0;
            hdat_q <= '0;
         end else begin
            resp_q <= mem_resp_data;
            hdat_q <= host_rdata;
         end
      end
   end else begin : g_latn
      logic hval_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            resp_q <= '0;
            hdat_q <= '0;
            hval_q <= 1'b0;
         end else begin
            hval_q <= l_tag.valid && l_tag.host;
            if (l_tag.valid && !l_tag.host) resp_q <= l_dat;
            if (l_tag.valid && l_tag.host) hdat_q <= l_dat;
         end
      end
      assign mem_resp_data = resp_q;
      assign host_rdata    = hdat_q;
      assign host_rvalid   = hval_q;
   end

endmodule
